// File: rtl/givens_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : givens_row_sequencer
// Brief    : Streams one matrix row pair-by-pair through an external CORDIC,
//            vectoring the pivot pair and rotating the rest by its angle.
//            Optional quadrant fix via macro GIVENS_QUAD_FIX_EN.
// Revision : 1.0
// ============================================================================
module givens_row_sequencer #(
    parameter int N_ELEMS = 4,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        out_last,
    output logic [31:0] angle,
    output logic        busy,
    output logic        err,
    input  logic        err_clr,
    output logic        cdc_enable,
    output logic        cdc_select,
    output logic [31:0] cdc_x,
    output logic [31:0] cdc_y,
    output logic [31:0] cdc_z,
    input  logic [31:0] cdc_x_out,
    input  logic [31:0] cdc_y_out,
    input  logic [31:0] cdc_z_out,
    input  logic        cdc_done
);

    localparam int c_cnt_w = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
    localparam int c_tmo_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N_ELEMS - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_issue = 3'd1;
    localparam logic [2:0] c_wait  = 3'd2;
    localparam logic [2:0] c_emit  = 3'd3;
    localparam logic [2:0] c_error = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_tmo_w-1:0] r_tmo;
    logic               r_run;
    logic [31:0]        r_out_a;
    logic [31:0]        r_out_b;
    logic [31:0]        r_angle;
    logic [31:0]        r_cdc_x;
    logic [31:0]        r_cdc_y;
    logic [31:0]        r_cdc_z;
    logic               r_cdc_sel;
    logic               r_last;
    logic               r_err;

    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic               w_pivot;
    logic               w_row_end;
    logic               w_in_hs;
    logic               w_out_hs;

    assign w_pivot   = (r_cnt == '0);
    assign w_row_end = (r_cnt == c_cnt_last);

    // r_run keeps in_ready low until the first edge after reset release
    assign in_ready  = r_run && (r_state == c_idle);
    assign w_in_hs   = in_valid && in_ready;
    assign out_valid = (r_state == c_emit);
    assign w_out_hs  = out_valid && out_ready;

    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign out_last   = r_last;
    assign angle      = r_angle;
    assign err        = r_err;
    assign busy       = !((r_state == c_idle) && w_pivot);
    assign cdc_enable = (r_state == c_issue);
    assign cdc_select = r_cdc_sel;
    assign cdc_x      = r_cdc_x;
    assign cdc_y      = r_cdc_y;
    assign cdc_z      = r_cdc_z;

`ifdef GIVENS_QUAD_FIX_EN
    logic r_flip;
    logic w_flip;

    // A negative pivot is mirrored into the right half-plane; the whole row follows
    assign w_flip = w_pivot ? in_a[31] : r_flip;
    assign w_a    = w_flip ? -in_a : in_a;
    assign w_b    = w_flip ? -in_b : in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flip <= 1'b0;
        end else if (w_in_hs) begin
            r_flip <= w_flip;
        end else if ((w_out_hs && w_row_end) || ((r_state == c_error) && err_clr)) begin
            r_flip <= 1'b0;
        end
    end
`else
    assign w_a = in_a;
    assign w_b = in_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_run     <= 1'b0;
            r_out_a   <= '0;
            r_out_b   <= '0;
            r_angle   <= '0;
            r_cdc_x   <= '0;
            r_cdc_y   <= '0;
            r_cdc_z   <= '0;
            r_cdc_sel <= 1'b0;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                c_idle: begin
                    if (w_in_hs) begin
                        r_cdc_x   <= w_a;
                        r_cdc_y   <= w_b;
                        r_cdc_sel <= w_pivot;
                        r_cdc_z   <= w_pivot ? 32'd0 : -r_angle;
                        r_state   <= c_issue;
                    end
                end
                c_issue: begin
                    r_tmo   <= '0;
                    r_state <= c_wait;
                end
                c_wait: begin
                    // done takes priority over a timeout expiring on the same cycle
                    if (cdc_done) begin
                        r_out_a <= cdc_x_out;
                        r_out_b <= w_pivot ? 32'd0 : cdc_y_out;
                        if (w_pivot) begin
                            r_angle <= cdc_z_out;
                        end
                        r_last  <= w_row_end;
                        r_state <= c_emit;
                    end else if (r_tmo == c_tmo_last) begin
                        r_err   <= 1'b1;
                        r_state <= c_error;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_emit: begin
                    if (out_ready) begin
                        r_cnt   <= w_row_end ? '0 : r_cnt + 1'b1;
                        r_state <= c_idle;
                    end
                end
                c_error: begin
                    if (err_clr) begin
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_givens_row_sequencer.sv
`default_nettype none
// Testbench for givens_row_sequencer: floating-point CORDIC responder plus a
// row-level reference model and a per-cycle output scoreboard.
module tb_givens_row_sequencer;

    localparam int N_ELEMS = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_a, in_b, out_a, out_b, angle;
    logic        busy, err, err_clr, cdc_enable, cdc_select, cdc_done;
    logic [31:0] cdc_x, cdc_y, cdc_z, cdc_x_out, cdc_y_out, cdc_z_out;

    always #5 clk = ~clk;

    givens_row_sequencer #(.N_ELEMS(N_ELEMS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_last(out_last), .angle(angle), .busy(busy), .err(err), .err_clr(err_clr),
        .cdc_enable(cdc_enable), .cdc_select(cdc_select),
        .cdc_x(cdc_x), .cdc_y(cdc_y), .cdc_z(cdc_z),
        .cdc_x_out(cdc_x_out), .cdc_y_out(cdc_y_out), .cdc_z_out(cdc_z_out),
        .cdc_done(cdc_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] r2fx(input real r);
        return $rtoi(r * 16777216.0);
    endfunction

    function automatic real fx2r(input logic [31:0] x);
        return $itor($signed(x)) / 16777216.0;
    endfunction

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input logic [31:0] act, input logic [31:0] exp);
        longint d;
        d = longint'($signed(act)) - longint'($signed(exp));
        if (d < 0) d = -d;
        n_checks++;
        if (d > 4096) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (+/-2^-12)", name, act, exp);
        end
    endtask

    // CORDIC responder: ideal math, done pulsed done_delay cycles after enable
    int  done_delay = 1;
    bit  hold_done  = 0;
    int  pend       = 0;

    always @(negedge clk) begin
        real x, y, th;
        cdc_done = 1'b0;
        if (hold_done) pend = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) cdc_done = 1'b1;
        end
        if (cdc_enable) begin
            x = fx2r(cdc_x);
            y = fx2r(cdc_y);
            if (cdc_select) begin
                cdc_x_out = r2fx($sqrt(x * x + y * y));
                cdc_y_out = 32'h0000_0123;     // residual, must never reach out_b
                cdc_z_out = r2fx($atan2(y, x));
            end else begin
                th = fx2r(cdc_z);
                cdc_x_out = r2fx(x * $cos(th) - y * $sin(th));
                cdc_y_out = r2fx(x * $sin(th) + y * $cos(th));
                cdc_z_out = 32'h0;
            end
            pend = done_delay;
        end
    end

    // Row-level reference model
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ang;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          m_idx = 0;
    real         m_ang = 0.0;
`ifdef GIVENS_QUAD_FIX_EN
    bit          m_flip = 0;
`endif

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk_near("out_a", out_a, exp_q[0].a);
                chk_near("out_b", out_b, exp_q[0].b);
                chk_eq("out_last", 32'(out_last), 32'(exp_q[0].last));
                chk_near("angle", angle, exp_q[0].ang);
                chk_eq("in_ready_in_emit", 32'(in_ready), 32'd0);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    task automatic send_pair(input real ra_in, input real rb_in, input int hold,
                             output logic [31:0] oa, output logic [31:0] ob,
                             output logic [31:0] ang, output logic [31:0] cx,
                             output logic [31:0] cy);
        logic [31:0] a, b, ea, eb, ez;
        real         ra, rb;
        logic        sel;
        exp_t        e;
        int          t, lat;
        a  = r2fx(ra_in);
        b  = r2fx(rb_in);
        ea = a;
        eb = b;
        ra = fx2r(a);
        rb = fx2r(b);
`ifdef GIVENS_QUAD_FIX_EN
        if (m_idx == 0) m_flip = (ra < 0.0);
        if (m_flip) begin
            ea = -a; eb = -b; ra = -ra; rb = -rb;
        end
`endif
        sel    = (m_idx == 0);
        e.last = (m_idx == N_ELEMS - 1);
        if (sel) begin
            m_ang = $atan2(rb, ra);
            e.a   = r2fx($sqrt(ra * ra + rb * rb));
            e.b   = 32'h0;
            ez    = 32'h0;
        end else begin
            // rotate by -angle: pivot direction maps onto the x axis
            e.a = r2fx(ra * $cos(m_ang) + rb * $sin(m_ang));
            e.b = r2fx(rb * $cos(m_ang) - ra * $sin(m_ang));
            ez  = r2fx(-m_ang);
        end
        e.ang = r2fx(m_ang);
        m_idx = e.last ? 0 : m_idx + 1;
`ifdef GIVENS_QUAD_FIX_EN
        if (e.last) m_flip = 0;
`endif
        oa = 0; ob = 0; ang = 0; cx = 0; cy = 0;

        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk_eq("in_ready_before_pair", 32'(in_ready), 32'd1);
        if (!in_ready) return;
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        chk_eq("cdc_enable", 32'(cdc_enable), 32'd1);
        chk_eq("cdc_select", 32'(cdc_select), 32'(sel));
        chk_eq("cdc_x", cdc_x, ea);
        chk_eq("cdc_y", cdc_y, eb);
        chk_near("cdc_z", cdc_z, ez);
        cx = cdc_x;
        cy = cdc_y;
        @(negedge clk);
        chk_eq("cdc_enable_one_cycle", 32'(cdc_enable), 32'd0);
        chk_eq("cdc_x_hold", cdc_x, ea);
        lat = 2;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk_eq("out_valid_arrives", 32'(out_valid), 32'd1);
        if (done_delay == 1) chk_eq("latency", 32'(lat), 32'd3);
        oa  = out_a;
        ob  = out_b;
        ang = angle;
        repeat (hold) @(negedge clk);
        if (hold > 0) chk_eq("out_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_ctl"}, 32'({in_ready, out_valid, out_last, busy, err, cdc_enable, cdc_select}), 32'd0);
        chk_eq({tag, "_data"}, out_a | out_b | angle, 32'd0);
        chk_eq({tag, "_cdc"}, cdc_x | cdc_y | cdc_z, 32'd0);
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_idx = 0;
        m_ang = 0.0;
`ifdef GIVENS_QUAD_FIX_EN
        m_flip = 0;
`endif
    endtask

    initial begin
        logic [31:0] oa, ob, ang, cx, cy;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        cdc_done = 1'b0; cdc_x_out = '0; cdc_y_out = '0; cdc_z_out = '0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk_eq("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk_eq("in_ready_after_edge", 32'(in_ready), 32'd1);
        chk_eq("busy_idle_cnt0", 32'(busy), 32'd0);

        // Row 1
        send_pair(3.0, 4.0, 0, oa, ob, ang, cx, cy);
        chk_near("pin_pivot_a", oa, 32'h0500_0000);
        chk_eq("pin_pivot_b", ob, 32'h0000_0000);
        chk_near("pin_angle", ang, 32'h00ED_6335);
        chk_eq("busy_mid_row", 32'(busy), 32'd1);
        send_pair(4.0, -3.0, 0, oa, ob, ang, cx, cy);
        chk_near("pin_rot_a", oa, 32'h0000_0000);
        chk_near("pin_rot_b", ob, 32'hFB00_0000);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk_eq("err_clr_idle_ready", 32'(in_ready), 32'd1);
        chk_eq("err_clr_idle_err", 32'(err), 32'd0);
        send_pair(1.0, 2.0, 0, oa, ob, ang, cx, cy);
        send_pair(-0.5, 0.25, 0, oa, ob, ang, cx, cy);
        chk_eq("row_end_busy", 32'(busy), 32'd0);

        // Row 2: back-pressure, late done, then a timeout
        send_pair(2.0, -1.0, 5, oa, ob, ang, cx, cy);
        done_delay = TIMEOUT;
        send_pair(1.5, 0.5, 0, oa, ob, ang, cx, cy);
        chk_eq("done_wins_no_err", 32'(err), 32'd0);
        done_delay = 1;
        hold_done  = 1;
        in_valid = 1'b1; in_a = r2fx(0.75); in_b = r2fx(0.25);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (TIMEOUT - 1) @(negedge clk);
        chk_eq("err_before_timeout", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        chk_eq("err_timeout", 32'(err), 32'd1);
        chk_eq("error_in_ready", 32'(in_ready), 32'd0);
        chk_eq("error_out_valid", 32'(out_valid), 32'd0);
        chk_eq("error_busy", 32'(busy), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        hold_done = 0;
        chk_eq("err_cleared", 32'(err), 32'd0);
        chk_eq("err_clr_ready", 32'(in_ready), 32'd1);
        chk_eq("err_clr_cnt0", 32'(busy), 32'd0);
        reset_model();

        // Reset abandons a partial row
        send_pair(0.6, 0.8, 0, oa, ob, ang, cx, cy);
        send_pair(1.0, 1.0, 0, oa, ob, ang, cx, cy);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_row_reset");
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pair(2.0, 2.0, 0, oa, ob, ang, cx, cy);
        chk_near("post_reset_pivot_b", ob, 32'h0000_0000);

`ifdef GIVENS_QUAD_FIX_EN
        rst_n = 1'b0;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pair(-3.0, 4.0, 0, oa, ob, ang, cx, cy);
        chk_eq("quad_cdc_x", cx, 32'h0300_0000);
        chk_eq("quad_cdc_y", cy, 32'hFC00_0000);
        chk_near("quad_out_a", oa, 32'h0500_0000);
        chk_near("quad_angle", ang, 32'hFF12_9CCB);
        send_pair(-4.0, -3.0, 0, oa, ob, ang, cx, cy);
`endif

        repeat (3) @(negedge clk);
        chk_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
